// File: rtl/hdlc_pkg.sv
// Shared definitions for the Hdlc register bus and the receive drain engine.
// Register map, Rx_SC bit positions and drain FSM state encoding.
package hdlc_pkg;

    localparam logic [2:0] TX_SC   = 3'h0;
    localparam logic [2:0] TX_BUFF = 3'h1;
    localparam logic [2:0] RX_SC   = 3'h2;
    localparam logic [2:0] RX_BUFF = 3'h3;
    localparam logic [2:0] RX_LEN  = 3'h4;

    localparam int RX_SC_FERR  = 2;
    localparam int RX_SC_ABORT = 3;
    localparam int RX_SC_OVF   = 4;

    localparam logic [7:0] RX_DROP_CMD = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SC,
        ST_CAP_SC,
        ST_RD_LEN,
        ST_CAP_LEN,
        ST_RD_BYTE,
        ST_CAP_BYTE,
        ST_OUT,
        ST_DROP,
        ST_WAIT_CLR
    } drain_state_t;

endpackage

// File: rtl/hdlc_bus_rd.sv
// Single-beat Hdlc register read: one-cycle strobe, data valid next cycle.
// Kept generic so a transmit-side loader can reuse it.
module hdlc_bus_rd (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_start,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_re,
    output logic [2:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_valid
);

    logic r_pend;

    // Remember that a read was issued so its data can be flagged next cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= i_start;
        end
    end

    assign o_re    = i_start;
    assign o_addr  = i_start ? i_addr : 3'h0;
    assign o_data  = r_pend ? i_rd_data : 8'h00;
    assign o_valid = r_pend;

endmodule

// File: rtl/hdlc_rx_drain.sv
// Drains received Hdlc frames into a byte stream, dropping bad frames.
// Status and length are read first; each byte costs read, capture, handshake.
module hdlc_rx_drain
    import hdlc_pkg::*;
#(
    parameter int MAX_LEN = 128,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Rx_Ready,
    output logic [2:0]       Bus_Address,
    output logic             Bus_ReadEnable,
    output logic             Bus_WriteEnable,
    output logic [7:0]       Bus_WrData,
    input  logic [7:0]       Bus_RdData,
    output logic [7:0]       M_Data,
    output logic             M_Valid,
    input  logic             M_Ready,
    output logic             M_Last,
    output logic             M_Error,
    output logic [CNT_W-1:0] FrameCount,
    output logic [CNT_W-1:0] DropCount
);

    drain_state_t r_state;
    drain_state_t w_next;

    logic       w_rd_start;
    logic [2:0] w_rd_addr;
    logic       w_rd_re;
    logic [2:0] w_rd_a;
    logic [7:0] w_rd_data;
    logic       w_rd_valid;
    logic       w_sc_bad;
    logic       w_len_bad;
    logic       w_wr;
    logic       w_hs;

    logic [7:0]       r_rem;
    logic             r_ovf;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_last;
    logic             r_err;
    logic [CNT_W-1:0] r_fcnt;
    logic [CNT_W-1:0] r_dcnt;

    hdlc_bus_rd u_rd (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_start   (w_rd_start),
        .i_addr    (w_rd_addr),
        .i_rd_data (Bus_RdData),
        .o_re      (w_rd_re),
        .o_addr    (w_rd_a),
        .o_data    (w_rd_data),
        .o_valid   (w_rd_valid)
    );

    assign w_sc_bad  = w_rd_data[RX_SC_FERR] | w_rd_data[RX_SC_ABORT];
    assign w_len_bad = (w_rd_data == 8'd0) ||
                       (32'(w_rd_data) > 32'(MAX_LEN));
    assign w_wr      = (r_state == ST_DROP);
    assign w_hs      = r_valid & M_Ready;

    assign Bus_ReadEnable  = w_rd_re & ~w_wr;
    assign Bus_WriteEnable = w_wr;
    assign Bus_Address     = w_wr ? RX_SC : w_rd_a;
    assign Bus_WrData      = w_wr ? RX_DROP_CMD : 8'h00;

    assign M_Data     = r_data;
    assign M_Valid    = r_valid;
    assign M_Last     = r_last;
    assign M_Error    = r_err;
    assign FrameCount = r_fcnt;
    assign DropCount  = r_dcnt;

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and read-strobe requests.
    always_comb begin
        w_next     = r_state;
        w_rd_start = 1'b0;
        w_rd_addr  = RX_SC;
        case (r_state)
            ST_IDLE: begin
                if (Enable && Rx_Ready) begin
                    w_next = ST_RD_SC;
                end
            end
            ST_RD_SC: begin
                w_rd_start = 1'b1;
                w_rd_addr  = RX_SC;
                w_next     = ST_CAP_SC;
            end
            ST_CAP_SC: begin
                w_next = (w_rd_valid && !w_sc_bad) ? ST_RD_LEN : ST_DROP;
            end
            ST_RD_LEN: begin
                w_rd_start = 1'b1;
                w_rd_addr  = RX_LEN;
                w_next     = ST_CAP_LEN;
            end
            ST_CAP_LEN: begin
                w_next = w_len_bad ? ST_DROP : ST_RD_BYTE;
            end
            ST_RD_BYTE: begin
                w_rd_start = 1'b1;
                w_rd_addr  = RX_BUFF;
                w_next     = ST_CAP_BYTE;
            end
            ST_CAP_BYTE: begin
                w_next = ST_OUT;
            end
            ST_OUT: begin
                if (w_hs) begin
                    w_next = r_last ? ST_WAIT_CLR : ST_RD_BYTE;
                end
            end
            ST_DROP: begin
                w_next = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (!Rx_Ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame context, stream output register and statistics.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rem   <= 8'd0;
            r_ovf   <= 1'b0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_fcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                ST_CAP_SC: begin
                    r_ovf <= w_rd_data[RX_SC_OVF];
                end
                ST_CAP_LEN: begin
                    r_rem <= w_rd_data;
                end
                ST_CAP_BYTE: begin
                    r_data  <= w_rd_data;
                    r_valid <= 1'b1;
                    r_last  <= (r_rem == 8'd1);
                    r_err   <= (r_rem == 8'd1) & r_ovf;
                end
                ST_OUT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_err   <= 1'b0;
                        r_rem   <= r_rem - 8'd1;
                        if (r_last) begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
